dual_lane_serializer: RTL and testbench
=======================================

Name: dual_lane_serializer

Overview:
Transmit-side counterpart to the two-lane serial capture front end. Accepts one pair of WIDTH-bit parallel words (a, b) per valid/ready handshake. Shifts them out MSB-first, one bit per clock, on a 2-bit lane bus: lane[0] carries a, lane[1] carries b. A downstream shift-left capture register ({sr[WIDTH-2:0], lane[i]}) therefore holds the words exactly after WIDTH consecutive bit cycles.

Parameters:
WIDTH, 16, bits per word per lane (>= 2)
GAP, 1, idle cycles inserted after each word (0 = back-to-back words allowed)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
a_data  input  WIDTH  word for lane 0, sampled on handshake
b_data  input  WIDTH  word for lane 1, sampled on handshake
in_valid  input  1  a_data/b_data valid
in_ready  output  1  block can accept a word pair this cycle
lane  output  2  serial bits {b_bit, a_bit}, registered
frame  output  1  high during the cycle carrying the MSB of a word
last  output  1  high during the cycle carrying the LSB of a word
busy  output  1  high in SHIFT or GAP state
tx_count  output  16  number of completed words, wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; lane=2'b00, frame=0, last=0, busy=0, tx_count=0; shift registers and counters cleared. in_ready is forced 0 while rst=1.
- Reset mid-word aborts the transfer. lane returns to 0 at that edge. No last pulse is produced and tx_count is not incremented.
- Handshake: a transfer occurs at an edge where in_valid=1 and in_ready=1. a_data/b_data are captured into internal shift registers. Input changes after capture have no effect.
- in_ready (combinational from registered state):
  - 1 in IDLE (rst=0).
  - 1 in SHIFT on the LSB cycle only when GAP=0.
  - 0 otherwise.
- States:
  - IDLE: lane=0, frame=0, last=0. On handshake -> SHIFT.
  - SHIFT: bit counter k runs 0..WIDTH-1. In cycle k, lane={b[WIDTH-1-k], a[WIDTH-1-k]}. frame=1 when k=0; last=1 when k=WIDTH-1. On the k=WIDTH-1 cycle:
    - GAP>0: -> GAP.
    - GAP=0 with handshake: reload, stay in SHIFT at k=0.
    - GAP=0 without handshake: -> IDLE.
  - GAP: lane=0 for exactly GAP cycles, then -> IDLE. in_ready=0 throughout.
- Latency: lane/frame for a new word are valid on the first cycle after the handshake edge. The LSB appears WIDTH cycles after the handshake edge.
- tx_count increments by 1 at the edge ending each last=1 cycle, and wraps modulo 2^16.
- busy = (state != IDLE).
- Throughput:
  - GAP=0: one word pair per WIDTH cycles.
  - GAP>0: one word pair per WIDTH+GAP+1 cycles minimum (the extra cycle is IDLE).
- in_valid held high with in_ready=0 is legal. The data is held by the source; no word is dropped or duplicated.
- All outputs except in_ready are registered; there are no combinational paths from inputs to lane/frame/last.

Test Plan:
1. Reset, then handshake a=0xA5C3, b=0x0F0F (GAP=1) -> lane[0] carries 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 and lane[1] carries 0,0,0,0,1,1,1,1 repeated, over 16 cycles. frame is high on the first cycle only, last on the 16th. A behavioural capture shift register then holds 0xA5C3/0x0F0F; tx_count=1.
2. GAP=0, in_valid held high with 3 queued pairs (0x0001/0x8000, 0xFFFF/0x0000, 0x1234/0x4321) -> 48 contiguous bit cycles with no idle cycle. frame is at cycles 0, 16, 32; in_ready pulses on cycles 15 and 31; tx_count=3; captured words match.
3. GAP=2, back-to-back in_valid -> after last, exactly 2 cycles of lane=0 with in_ready=0, plus 1 IDLE cycle with in_ready=1. The next frame comes 19 cycles after the previous frame.
4. Assert rst for 1 cycle at bit 7 of a=0xFFFF, b=0xFFFF -> lane=00 at the following edge. No last pulse, tx_count stays 0, in_ready=0 during rst and 1 afterwards. The next word transmits correctly from its MSB.
5. Change a_data/b_data every cycle after the handshake of 0x8001/0x7FFE -> output bit stream still equals 0x8001/0x7FFE.
6. Preload 65535 completions (force or run 65535 words), send one more -> tx_count wraps to 0x0000 at the final last edge.

Source files
------------

// File: rtl/dual_lane_serializer.sv
// Two-lane MSB-first serializer: one (a, b) word pair per handshake, lane[0]=a, lane[1]=b,
// with frame/last markers, an optional idle gap between words and a completed-word counter.
module dual_lane_serializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       lane,
  output logic             frame,
  output logic             last,
  output logic             busy,
  output logic [15:0]      tx_count
);

  localparam int unsigned CNT_W    = $clog2(WIDTH);
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned CNT_LAST = WIDTH - 1;
  localparam int unsigned CNT_PREV = WIDTH - 2;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam bit          HAS_GAP  = (GAP != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]         lane_d;
  logic               frame_d;
  logic               last_d;
  logic               busy_d;
  logic [15:0]        tx_count_d;
  logic               on_lsb;
  logic               hs;
  logic               load;

  // LSB cycle of the current word is the only point where a gapless reload can happen
  assign on_lsb   = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_W'(CNT_LAST));
  assign in_ready = !rst && ((state_q == ST_IDLE) || (!HAS_GAP && on_lsb));
  assign hs       = in_valid && in_ready;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    lane_d     = 2'b00;
    frame_d    = 1'b0;
    last_d     = 1'b0;
    tx_count_d = tx_count;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hs) load = 1'b1;
      end
      ST_SHIFT: begin
        if (on_lsb) begin
          tx_count_d = tx_count + 16'd1;
          if (HAS_GAP) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else if (hs) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          // Present the next bit pair and advance the remaining bits
          lane_d    = {b_sr_q[WIDTH-1], a_sr_q[WIDTH-1]};
          a_sr_d    = {a_sr_q[WIDTH-2:0], 1'b0};
          b_sr_d    = {b_sr_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          last_d    = (bit_cnt_q == CNT_W'(CNT_PREV));
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // MSB goes straight to the lane register; the rest waits in the shift registers
    if (load) begin
      state_d   = ST_SHIFT;
      lane_d    = {b_data[WIDTH-1], a_data[WIDTH-1]};
      a_sr_d    = {a_data[WIDTH-2:0], 1'b0};
      b_sr_d    = {b_data[WIDTH-2:0], 1'b0};
      bit_cnt_d = '0;
      frame_d   = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      lane      <= 2'b00;
      frame     <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      tx_count  <= 16'd0;
    end else begin
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      lane      <= lane_d;
      frame     <= frame_d;
      last      <= last_d;
      busy      <= busy_d;
      tx_count  <= tx_count_d;
    end
  end

endmodule

// File: tb/tb_dual_lane_serializer.sv
// Directed bench for dual_lane_serializer: three instances with GAP = 0, 1 and 2.
module tb_dual_lane_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_data, b_data;
  logic        valid_g0, valid_g1, valid_g2;

  logic        ready_g0, ready_g1, ready_g2;
  logic [1:0]  lane_g0, lane_g1, lane_g2;
  logic        frame_g0, frame_g1, frame_g2;
  logic        last_g0, last_g1, last_g2;
  logic        busy_g0, busy_g1, busy_g2;
  logic [15:0] cnt_g0, cnt_g1, cnt_g2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dual_lane_serializer #(.WIDTH(16), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .a_data(a_data), .b_data(b_data), .in_valid(valid_g0),
    .in_ready(ready_g0), .lane(lane_g0), .frame(frame_g0), .last(last_g0),
    .busy(busy_g0), .tx_count(cnt_g0));

  dual_lane_serializer #(.WIDTH(16), .GAP(1)) u_g1 (
    .clk(clk), .rst(rst), .a_data(a_data), .b_data(b_data), .in_valid(valid_g1),
    .in_ready(ready_g1), .lane(lane_g1), .frame(frame_g1), .last(last_g1),
    .busy(busy_g1), .tx_count(cnt_g1));

  dual_lane_serializer #(.WIDTH(16), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .a_data(a_data), .b_data(b_data), .in_valid(valid_g2),
    .in_ready(ready_g2), .lane(lane_g2), .frame(frame_g2), .last(last_g2),
    .busy(busy_g2), .tx_count(cnt_g2));

  task automatic test_reset();
    rst = 1'b1; valid_g0 = 1'b0; valid_g1 = 1'b0; valid_g2 = 1'b0;
    a_data = 16'h0; b_data = 16'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({lane_g1, frame_g1, last_g1, busy_g1} !== 5'b0 || cnt_g1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: lane=%b frame=%b last=%b busy=%b cnt=%h, need all zero",
               lane_g1, frame_g1, last_g1, busy_g1, cnt_g1);
    end
    checks++;
    if (ready_g1 !== 1'b0) begin
      errors++; $display("FAIL reset_ready: in_ready=%b, need 0", ready_g1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready_g1 !== 1'b1) begin
      errors++; $display("FAIL idle_ready: in_ready=%b, need 1", ready_g1);
    end
  endtask

  // GAP=1 single word: bit order, markers, capture and count
  task automatic test_single_word();
    logic [15:0] wa, wb, cap_a, cap_b;
    wa = 16'hA5C3; wb = 16'h0F0F; cap_a = '0; cap_b = '0;
    @(negedge clk);
    a_data = wa; b_data = wb; valid_g1 = 1'b1;
    @(negedge clk);
    valid_g1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (lane_g1 !== {wb[15-k], wa[15-k]} || frame_g1 !== (k == 0) || last_g1 !== (k == 15)
          || busy_g1 !== 1'b1) begin
        errors++;
        $display("FAIL single_bit%0d: lane=%b frame=%b last=%b busy=%b, need lane=%b frame=%b last=%b busy=1",
                 k, lane_g1, frame_g1, last_g1, busy_g1, {wb[15-k], wa[15-k]}, k == 0, k == 15);
      end
      cap_a = {cap_a[14:0], lane_g1[0]};
      cap_b = {cap_b[14:0], lane_g1[1]};
      @(negedge clk);
    end
    checks++;
    if (cap_a !== 16'hA5C3 || cap_b !== 16'h0F0F) begin
      errors++; $display("FAIL single_capture: a=%h b=%h, need a5c3/0f0f", cap_a, cap_b);
    end
    checks++;
    if (cnt_g1 !== 16'd1 || lane_g1 !== 2'b00 || ready_g1 !== 1'b0 || busy_g1 !== 1'b1) begin
      errors++;
      $display("FAIL single_gap: cnt=%h lane=%b ready=%b busy=%b, need cnt=1 lane=00 ready=0 busy=1",
               cnt_g1, lane_g1, ready_g1, busy_g1);
    end
    @(negedge clk);
    checks++;
    if (busy_g1 !== 1'b0 || ready_g1 !== 1'b1) begin
      errors++; $display("FAIL single_idle: busy=%b ready=%b, need 0/1", busy_g1, ready_g1);
    end
  endtask

  // GAP=0 with three queued pairs: 48 contiguous bit cycles
  task automatic test_back_to_back();
    logic [15:0] ea[3], eb[3];
    logic [15:0] cap_a, cap_b;
    int idx;
    bit hs_pending;
    ea[0] = 16'h0001; eb[0] = 16'h8000;
    ea[1] = 16'hFFFF; eb[1] = 16'h0000;
    ea[2] = 16'h1234; eb[2] = 16'h4321;
    cap_a = '0; cap_b = '0;
    idx = 0;
    a_data = ea[0]; b_data = eb[0]; valid_g0 = 1'b1;
    hs_pending = 1'b1;
    for (int c = 0; c < 48; c++) begin
      logic [15:0] xa, xb;
      int bitn;
      @(negedge clk);
      if (hs_pending) begin
        idx++;
        if (idx < 3) begin a_data = ea[idx]; b_data = eb[idx]; end
        else valid_g0 = 1'b0;
        hs_pending = 1'b0;
      end
      xa = ea[c/16]; xb = eb[c/16]; bitn = 15 - (c % 16);
      checks++;
      if (lane_g0 !== {xb[bitn], xa[bitn]} || frame_g0 !== (c % 16 == 0)
          || last_g0 !== (c % 16 == 15) || busy_g0 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_cycle%0d: lane=%b frame=%b last=%b busy=%b, need lane=%b frame=%b last=%b busy=1",
                 c, lane_g0, frame_g0, last_g0, busy_g0, {xb[bitn], xa[bitn]}, c % 16 == 0, c % 16 == 15);
      end
      checks++;
      if (ready_g0 !== (c % 16 == 15)) begin
        errors++; $display("FAIL b2b_ready%0d: in_ready=%b, need %b", c, ready_g0, c % 16 == 15);
      end
      cap_a = {cap_a[14:0], lane_g0[0]};
      cap_b = {cap_b[14:0], lane_g0[1]};
      if (c % 16 == 15) begin
        checks++;
        if (cap_a !== xa || cap_b !== xb) begin
          errors++; $display("FAIL b2b_capture%0d: a=%h b=%h, need %h/%h", c / 16, cap_a, cap_b, xa, xb);
        end
      end
      hs_pending = valid_g0 && ready_g0;
    end
    @(negedge clk);
    checks++;
    if (cnt_g0 !== 16'd3 || busy_g0 !== 1'b0 || lane_g0 !== 2'b00) begin
      errors++;
      $display("FAIL b2b_end: cnt=%h busy=%b lane=%b, need cnt=3 busy=0 lane=00", cnt_g0, busy_g0, lane_g0);
    end
  endtask

  // GAP=2 with in_valid held: frame-to-frame spacing of 19 cycles
  task automatic test_gap_spacing();
    a_data = 16'h1357; b_data = 16'h2468; valid_g2 = 1'b1;
    for (int c = 0; c < 38; c++) begin
      bit ex_frame, ex_last, ex_ready, ex_busy, ex_quiet;
      @(negedge clk);
      if (c == 19) valid_g2 = 1'b0;
      ex_frame = (c == 0) || (c == 19);
      ex_last  = (c == 15) || (c == 34);
      ex_ready = (c == 18) || (c == 37);
      ex_busy  = !ex_ready;
      ex_quiet = (c >= 16 && c <= 18) || (c >= 35);
      checks++;
      if (frame_g2 !== ex_frame || last_g2 !== ex_last || ready_g2 !== ex_ready || busy_g2 !== ex_busy
          || (ex_quiet && lane_g2 !== 2'b00)) begin
        errors++;
        $display("FAIL gap_cycle%0d: frame=%b last=%b ready=%b busy=%b lane=%b, need %b %b %b %b quiet=%b",
                 c, frame_g2, last_g2, ready_g2, busy_g2, lane_g2, ex_frame, ex_last, ex_ready, ex_busy, ex_quiet);
      end
    end
    checks++;
    if (cnt_g2 !== 16'd2) begin
      errors++; $display("FAIL gap_count: cnt=%h, need 2", cnt_g2);
    end
  endtask

  // Reset at bit 7 of a word, then a clean word from its MSB
  task automatic test_mid_reset();
    logic [15:0] wa, wb;
    a_data = 16'hFFFF; b_data = 16'hFFFF; valid_g1 = 1'b1;
    @(negedge clk);
    valid_g1 = 1'b0;
    for (int k = 0; k < 7; k++) @(negedge clk);
    checks++;
    if (lane_g1 !== 2'b11 || last_g1 !== 1'b0) begin
      errors++; $display("FAIL midrst_bit7: lane=%b last=%b, need 11/0", lane_g1, last_g1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ready_g1 !== 1'b0) begin
      errors++; $display("FAIL midrst_ready_in_rst: in_ready=%b, need 0", ready_g1);
    end
    @(negedge clk);
    checks++;
    if (lane_g1 !== 2'b00 || last_g1 !== 1'b0 || busy_g1 !== 1'b0 || cnt_g1 !== 16'd0) begin
      errors++;
      $display("FAIL midrst_abort: lane=%b last=%b busy=%b cnt=%h, need 00/0/0/0000",
               lane_g1, last_g1, busy_g1, cnt_g1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready_g1 !== 1'b1) begin
      errors++; $display("FAIL midrst_ready_after: in_ready=%b, need 1", ready_g1);
    end
    wa = 16'h00FF; wb = 16'hFF00;
    a_data = wa; b_data = wb; valid_g1 = 1'b1;
    @(negedge clk);
    valid_g1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (lane_g1 !== {wb[15-k], wa[15-k]} || frame_g1 !== (k == 0) || last_g1 !== (k == 15)) begin
        errors++;
        $display("FAIL midrst_word_bit%0d: lane=%b frame=%b last=%b, need lane=%b frame=%b last=%b",
                 k, lane_g1, frame_g1, last_g1, {wb[15-k], wa[15-k]}, k == 0, k == 15);
      end
      @(negedge clk);
    end
    checks++;
    if (cnt_g1 !== 16'd1) begin
      errors++; $display("FAIL midrst_count: cnt=%h, need 1", cnt_g1);
    end
    @(negedge clk);
  endtask

  // Input churn after capture must not disturb the word in flight
  task automatic test_input_hold();
    logic [15:0] wa, wb, cap_a, cap_b;
    wa = 16'h8001; wb = 16'h7FFE; cap_a = '0; cap_b = '0;
    a_data = wa; b_data = wb; valid_g1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a_data = 16'($urandom); b_data = 16'($urandom);
      if (k == 15) valid_g1 = 1'b0;
      cap_a = {cap_a[14:0], lane_g1[0]};
      cap_b = {cap_b[14:0], lane_g1[1]};
    end
    checks++;
    if (cap_a !== 16'h8001 || cap_b !== 16'h7FFE) begin
      errors++; $display("FAIL hold_capture: a=%h b=%h, need 8001/7ffe", cap_a, cap_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_g1 !== 1'b0 || cnt_g1 !== 16'd2) begin
      errors++; $display("FAIL hold_single: busy=%b cnt=%h, need 0/0002", busy_g1, cnt_g1);
    end
  endtask

  // Completed-word counter wraps from 0xFFFF to 0x0000
  task automatic test_count_wrap();
    @(negedge clk);
    force u_g0.tx_count = 16'hFFFF;
    @(posedge clk);
    #1;
    release u_g0.tx_count;
    @(negedge clk);
    a_data = 16'h0F0F; b_data = 16'hF0F0; valid_g0 = 1'b1;
    @(negedge clk);
    valid_g0 = 1'b0;
    for (int k = 0; k < 15; k++) @(negedge clk);
    checks++;
    if (last_g0 !== 1'b1 || cnt_g0 !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_before: last=%b cnt=%h, need 1/ffff", last_g0, cnt_g0);
    end
    @(negedge clk);
    checks++;
    if (cnt_g0 !== 16'h0000 || busy_g0 !== 1'b0) begin
      errors++; $display("FAIL wrap_after: cnt=%h busy=%b, need 0000/0", cnt_g0, busy_g0);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap_spacing();
    test_mid_reset();
    test_input_hold();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
